// File: rtl/piece_write_sched.sv
// piece_write_sched
//   Arbitrates which requester may update the 22x10 active-piece layer each cycle:
//   spawn, hold/swap, rotate, shift left/right, soft drop or gravity. At most one
//   grant per cycle. All outputs are registered, so a decision made in cycle N is
//   visible in cycle N+1.
//
// Ports
//   Clk, Reset_n  clock, asynchronous active-low reset
//   state         game FSM state (3'b000 requests a spawn / restart)
//   keycode       current keyboard keycode (8'h00 = no key)
//   tick          one-cycle gravity pulse
//   can_*         collision checker verdicts for each move
//   swap_empty    hold register is empty
//   write_en      one-cycle strobe to the write mux
//   write_sel     write mux source (held while write_en = 0)
//   hold_load     one-cycle pulse; hold register captures the current piece
//   lock_req      one-cycle pulse; landed piece must merge into the board
//   swap_used     a swap has already been used for the current piece
module piece_write_sched #(
   parameter int unsigned DAS_CYCLES = 10000000,
   parameter int unsigned ARR_CYCLES = 2500000,
   parameter int unsigned CNT_W      = 24,
   parameter logic [7:0]  KEY_ROT    = 8'h1A,
   parameter logic [7:0]  KEY_SWAP   = 8'h06,
   parameter logic [7:0]  KEY_LEFT   = 8'h04,
   parameter logic [7:0]  KEY_RIGHT  = 8'h07,
   parameter logic [7:0]  KEY_DOWN   = 8'h16
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [2:0] state,
   input  logic [7:0] keycode,
   input  logic       tick,
   input  logic       can_rotate,
   input  logic       can_left,
   input  logic       can_right,
   input  logic       can_drop,
   input  logic       can_swap,
   input  logic       swap_empty,
   output logic       write_en,
   output logic [2:0] write_sel,
   output logic       hold_load,
   output logic       lock_req,
   output logic       swap_used
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSpawn  = 2'd1;
   localparam logic [1:0] StActive = 2'd2;
   localparam logic [1:0] StLocked = 2'd3;

   localparam logic [2:0] SelSpawn    = 3'd1;
   localparam logic [2:0] SelRotate   = 3'd2;
   localparam logic [2:0] SelSwapNext = 3'd3;
   localparam logic [2:0] SelSwapHeld = 3'd4;
   localparam logic [2:0] SelLeft     = 3'd5;
   localparam logic [2:0] SelRight    = 3'd6;
   localparam logic [2:0] SelDown     = 3'd7;

   logic [1:0]       fsm_q, fsm_d;
   logic [7:0]       prev_key_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_pend_q, tick_pend_d;
   logic             swap_used_q, swap_used_d;
   logic             write_en_q, write_en_d;
   logic [2:0]       write_sel_q, write_sel_d;
   logic             hold_load_q, hold_load_d;
   logic             lock_req_q, lock_req_d;

   logic key_press, key_held, is_step_key, cnt_expire, step, gravity;

   assign key_press   = (keycode != prev_key_q) && (keycode != 8'h00);
   assign key_held    = (keycode == prev_key_q) && (keycode != 8'h00);
   assign is_step_key = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) ||
                        (keycode == KEY_DOWN);
   assign cnt_expire  = (cnt_q == CNT_W'(1));
   // A step fires on the press edge and again every time the repeat counter expires
   assign step        = is_step_key && (key_press || (key_held && cnt_expire));
   assign gravity     = tick || tick_pend_q;

   // Repeat counter: DAS delay after a press, ARR period afterwards, zero otherwise
   always_comb begin
      cnt_d = '0;
      if (fsm_q == StActive && is_step_key) begin
         if (key_press) begin
            cnt_d = CNT_W'(DAS_CYCLES);
         end else if (key_held && cnt_q != '0) begin
            cnt_d = cnt_expire ? CNT_W'(ARR_CYCLES) : cnt_q - CNT_W'(1);
         end
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      tick_pend_d = tick_pend_q;
      swap_used_d = swap_used_q;
      write_en_d  = 1'b0;
      write_sel_d = write_sel_q;
      hold_load_d = 1'b0;
      lock_req_d  = 1'b0;
      case (fsm_q)
         StIdle: begin
            if (state == 3'b000) fsm_d = StSpawn;
         end
         StSpawn: begin
            write_en_d  = 1'b1;
            write_sel_d = SelSpawn;
            swap_used_d = 1'b0;
            tick_pend_d = 1'b0;
            fsm_d       = StActive;
         end
         StActive: begin
            if (state == 3'b000) begin
               fsm_d = StSpawn;
            end else if (key_press && keycode == KEY_SWAP && can_swap && !swap_used_q) begin
               // Swap brings a fresh piece to the spawn rows, so pending gravity is dropped
               write_en_d  = 1'b1;
               write_sel_d = swap_empty ? SelSwapNext : SelSwapHeld;
               hold_load_d = 1'b1;
               swap_used_d = 1'b1;
               tick_pend_d = 1'b0;
            end else if (key_press && keycode == KEY_ROT && can_rotate) begin
               write_en_d  = 1'b1;
               write_sel_d = SelRotate;
               if (tick) tick_pend_d = 1'b1;
            end else if (step && keycode == KEY_LEFT && can_left) begin
               write_en_d  = 1'b1;
               write_sel_d = SelLeft;
               if (tick) tick_pend_d = 1'b1;
            end else if (step && keycode == KEY_RIGHT && can_right) begin
               write_en_d  = 1'b1;
               write_sel_d = SelRight;
               if (tick) tick_pend_d = 1'b1;
            end else if (step && keycode == KEY_DOWN && can_drop) begin
               // Soft drop already moves one row, so it absorbs any gravity request
               write_en_d  = 1'b1;
               write_sel_d = SelDown;
               tick_pend_d = 1'b0;
            end else if (gravity) begin
               tick_pend_d = 1'b0;
               if (can_drop) begin
                  write_en_d  = 1'b1;
                  write_sel_d = SelDown;
               end else begin
                  fsm_d = StLocked;
               end
            end
         end
         StLocked: begin
            lock_req_d = 1'b1;
            fsm_d      = StIdle;
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fsm_q       <= StIdle;
         prev_key_q  <= 8'h00;
         cnt_q       <= '0;
         tick_pend_q <= 1'b0;
         swap_used_q <= 1'b0;
         write_en_q  <= 1'b0;
         write_sel_q <= 3'd0;
         hold_load_q <= 1'b0;
         lock_req_q  <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         prev_key_q  <= keycode;
         cnt_q       <= cnt_d;
         tick_pend_q <= tick_pend_d;
         swap_used_q <= swap_used_d;
         write_en_q  <= write_en_d;
         write_sel_q <= write_sel_d;
         hold_load_q <= hold_load_d;
         lock_req_q  <= lock_req_d;
      end
   end

   assign write_en  = write_en_q;
   assign write_sel = write_sel_q;
   assign hold_load = hold_load_q;
   assign lock_req  = lock_req_q;
   assign swap_used = swap_used_q;

endmodule

// File: tb/tb_piece_write_sched.sv
// tb_piece_write_sched
//   Directed bench for piece_write_sched with short DAS/ARR timings. Each step
//   queues the expected registered outputs and compares them after the next edge.
module tb_piece_write_sched;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [2:0] state;
   logic [7:0] keycode;
   logic       tick, can_rotate, can_left, can_right, can_drop, can_swap, swap_empty;
   logic       write_en, hold_load, lock_req, swap_used;
   logic [2:0] write_sel;

   piece_write_sched #(
      .DAS_CYCLES(8),
      .ARR_CYCLES(4),
      .CNT_W     (24)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .state     (state),
      .keycode   (keycode),
      .tick      (tick),
      .can_rotate(can_rotate),
      .can_left  (can_left),
      .can_right (can_right),
      .can_drop  (can_drop),
      .can_swap  (can_swap),
      .swap_empty(swap_empty),
      .write_en  (write_en),
      .write_sel (write_sel),
      .hold_load (hold_load),
      .lock_req  (lock_req),
      .swap_used (swap_used)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string      tag;
      logic [6:0] exp;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   logic [2:0] exp_sel = 3'd0;
   logic       exp_su  = 1'b0;

   // Expected {write_en, write_sel, hold_load, lock_req, swap_used}
   task automatic expect_out(input string tag, input logic we, input logic [2:0] sel,
                             input logic hl, input logic lr);
      exp_t e;
      if (we) exp_sel = sel;
      e.tag = tag;
      e.exp = {we, exp_sel, hl, lr, exp_su};
      sb.push_back(e);
   endtask

   task automatic compare_front();
      exp_t       e;
      logic [6:0] obs;
      e   = sb.pop_front();
      obs = {write_en, write_sel, hold_load, lock_req, swap_used};
      checks++;
      assert (obs === e.exp) else begin
         errors++;
         $error("FAIL %s: observed we,sel,hl,lr,su=%b required=%b", e.tag, obs, e.exp);
      end
   endtask

   task automatic step_exp(input string tag, input logic we, input logic [2:0] sel,
                           input logic hl, input logic lr);
      expect_out(tag, we, sel, hl, lr);
      @(posedge Clk);
      #1;
      compare_front();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      Reset_n    = 1'b0;
      state      = 3'b111;
      keycode    = 8'h00;
      tick       = 1'b0;
      can_rotate = 1'b1;
      can_left   = 1'b1;
      can_right  = 1'b1;
      can_drop   = 1'b1;
      can_swap   = 1'b1;
      swap_empty = 1'b1;

      repeat (2) @(posedge Clk);
      #1;
      expect_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
      compare_front();
      Reset_n = 1'b1;

      // Spawn: request seen in IDLE, strobe two edges later, exactly once
      step_exp("idle", 1'b0, 3'd0, 1'b0, 1'b0);
      state = 3'b000;
      step_exp("to_spawn", 1'b0, 3'd0, 1'b0, 1'b0);
      state = 3'b111;
      step_exp("spawn", 1'b1, 3'd1, 1'b0, 1'b0);
      step_exp("spawn_once", 1'b0, 3'd0, 1'b0, 1'b0);

      // Swap into empty hold, then a second press is refused
      keycode = 8'h06;
      exp_su  = 1'b1;
      step_exp("swap_next", 1'b1, 3'd3, 1'b1, 1'b0);
      step_exp("swap_key_held", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("swap_release", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h06;
      step_exp("swap_used_block", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("swap_release2", 1'b0, 3'd0, 1'b0, 1'b0);

      // Rotate wins over tick; the tick is serviced on the next cycle
      keycode = 8'h1A;
      tick    = 1'b1;
      step_exp("rotate", 1'b1, 3'd2, 1'b0, 1'b0);
      tick = 1'b0;
      step_exp("pend_down", 1'b1, 3'd7, 1'b0, 1'b0);
      step_exp("pend_cleared", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("rot_release", 1'b0, 3'd0, 1'b0, 1'b0);

      // Auto-repeat left: press, then DAS=8, then every ARR=4
      keycode = 8'h04;
      for (int i = 1; i <= 30; i++) begin
         step_exp($sformatf("das_%0d", i), (i == 1) || (i >= 9 && ((i - 9) % 4) == 0),
                  3'd5, 1'b0, 1'b0);
      end
      keycode = 8'h00;
      step_exp("das_release", 1'b0, 3'd0, 1'b0, 1'b0);

      keycode = 8'h07;
      step_exp("right", 1'b1, 3'd6, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("right_release", 1'b0, 3'd0, 1'b0, 1'b0);

      // Blocked rotate is dropped and never retried while held
      can_rotate = 1'b0;
      keycode    = 8'h1A;
      step_exp("rot_blocked", 1'b0, 3'd0, 1'b0, 1'b0);
      can_rotate = 1'b1;
      step_exp("rot_no_retry", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("rot_release2", 1'b0, 3'd0, 1'b0, 1'b0);

      // Soft drop with tick in the same cycle: a single row only
      keycode = 8'h16;
      tick    = 1'b1;
      step_exp("drop_tick", 1'b1, 3'd7, 1'b0, 1'b0);
      tick = 1'b0;
      step_exp("drop_tick_consumed", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("drop_release", 1'b0, 3'd0, 1'b0, 1'b0);

      // Soft drop blocked: neither a grant nor a lock
      can_drop = 1'b0;
      keycode  = 8'h16;
      step_exp("drop_blocked", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("drop_blocked_rel", 1'b0, 3'd0, 1'b0, 1'b0);
      step_exp("no_lock", 1'b0, 3'd0, 1'b0, 1'b0);
      can_drop = 1'b1;

      // Restart from ACTIVE overrides a rotate press and clears swap_used
      state   = 3'b000;
      keycode = 8'h1A;
      step_exp("restart", 1'b0, 3'd0, 1'b0, 1'b0);
      state   = 3'b111;
      keycode = 8'h00;
      exp_su  = 1'b0;
      step_exp("respawn", 1'b1, 3'd1, 1'b0, 1'b0);

      // Swap with a held piece selects SWAP_HELD
      swap_empty = 1'b0;
      keycode    = 8'h06;
      exp_su     = 1'b1;
      step_exp("swap_held", 1'b1, 3'd4, 1'b1, 1'b0);
      swap_empty = 1'b1;
      keycode    = 8'h00;
      step_exp("swap_held_rel", 1'b0, 3'd0, 1'b0, 1'b0);

      // Gravity with no room locks for exactly one cycle, then IDLE
      can_drop = 1'b0;
      tick     = 1'b1;
      step_exp("tick_nodrop", 1'b0, 3'd0, 1'b0, 1'b0);
      tick = 1'b0;
      step_exp("lock", 1'b0, 3'd0, 1'b0, 1'b1);
      step_exp("lock_once", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h1A;
      tick    = 1'b1;
      step_exp("idle_ignore", 1'b0, 3'd0, 1'b0, 1'b0);
      tick = 1'b0;
      step_exp("idle_wait", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode  = 8'h00;
      can_drop = 1'b1;
      state    = 3'b000;
      step_exp("to_spawn2", 1'b0, 3'd0, 1'b0, 1'b0);
      state  = 3'b111;
      exp_su = 1'b0;
      step_exp("spawn2", 1'b1, 3'd1, 1'b0, 1'b0);

      // Asynchronous reset with a rotate press and a tick pending
      keycode = 8'h1A;
      tick    = 1'b1;
      #2;
      Reset_n = 1'b0;
      #1;
      exp_sel = 3'd0;
      exp_su  = 1'b0;
      expect_out("async_reset", 1'b0, 3'd0, 1'b0, 1'b0);
      compare_front();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      tick    = 1'b0;
      step_exp("post_reset_a", 1'b0, 3'd0, 1'b0, 1'b0);
      step_exp("post_reset_b", 1'b0, 3'd0, 1'b0, 1'b0);
      keycode = 8'h00;
      step_exp("post_reset_c", 1'b0, 3'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
